// File: rtl/jtdsp16_icache.sv
// jtdsp16_icache -- instruction fetch register and DSP16 do/redo loop cache.
//
// In IDLE every ROM word is registered straight through to the decoder.
// A `do` captures the N body words into a small local cache while they stream
// past (LOAD). The remaining K-1 passes are then replayed from the cache with
// the program counter frozen (REPLAY). A `redo` replays the cached body K
// times without touching ROM.
//
// Configuration macro: JTDSP16_REDO_EN
//   defined   : redo_en starts a replay of the cached body.
//   undefined : redo_en is ignored; do behaviour is unchanged.
module jtdsp16_icache #(
  parameter int CW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  input  logic        do_en,
  input  logic        redo_en,
  input  logic [3:0]  do_ni,
  input  logic [6:0]  do_k,
  output logic [15:0] instr,
  output logic        instr_ok,
  output logic        pc_hold,
  output logic        irq_mask,
  output logic [15:0] loop_start
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_REPLAY = 2'd2;

  localparam int DEPTH = (1 << CW) - 1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [3:0]    ni_q, ni_d;
  logic [6:0]    k_q, k_d;
  logic [15:0]   loop_start_q, loop_start_d;
  logic [15:0]   instr_q, instr_d;
  logic          instr_ok_q, instr_ok_d;

  // Loop body storage; no reset so it can map onto plain RAM.
  logic [15:0]   cache_q [DEPTH];
  logic          cache_we;

  logic          last_idx;
  logic          do_ok;
  logic          redo_ok;

  // Body index has reached the final instruction of the stored body.
  assign last_idx = (idx_q == CW'(ni_q - 4'd1));

  // A do with an empty body is a no-op.
  assign do_ok = do_en && (do_ni != 4'd0);

`ifdef JTDSP16_REDO_EN
  // redo needs a previously captured body and a non-zero count; a
  // simultaneous do always takes priority.
  assign redo_ok = redo_en && !do_en && (ni_q != 4'd0) && (do_k != 7'd0);
`else
  logic unused_redo;
  assign unused_redo = redo_en;
  assign redo_ok     = 1'b0;
`endif

  // Next-state logic for the loop controller and the instruction register.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    ni_d         = ni_q;
    k_d          = k_q;
    loop_start_d = loop_start_q;
    instr_d      = instr_q;
    instr_ok_d   = instr_ok_q;
    cache_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        instr_d    = rom_data;
        instr_ok_d = 1'b1;
        if (do_ok) begin
          ni_d         = do_ni;
          k_d          = do_k;
          loop_start_d = rom_addr;
          idx_d        = '0;
          state_d      = ST_LOAD;
        end else if (redo_ok) begin
          cnt_d   = do_k;
          idx_d   = '0;
          state_d = ST_REPLAY;
        end
      end

      ST_LOAD: begin
        // First pass: words come from ROM and are copied into the cache.
        instr_d  = rom_data;
        cache_we = 1'b1;
        if (last_idx) begin
          idx_d = '0;
          if (k_q <= 7'd1) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = k_q - 7'd1;
            state_d = ST_REPLAY;
          end
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end

      ST_REPLAY: begin
        // Later passes: words come from the cache while the PC is frozen.
        instr_d = cache_q[idx_q];
        if (last_idx) begin
          idx_d = '0;
          cnt_d = (cnt_q != 7'd0) ? cnt_q - 7'd1 : 7'd0;
          if (cnt_q <= 7'd1) begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Controller registers; reset aborts any loop in progress at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= 7'd0;
      ni_q         <= 4'd0;
      k_q          <= 7'd0;
      loop_start_q <= 16'd0;
      instr_q      <= 16'd0;
      instr_ok_q   <= 1'b0;
    end else if (cen) begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      ni_q         <= ni_d;
      k_q          <= k_d;
      loop_start_q <= loop_start_d;
      instr_q      <= instr_d;
      instr_ok_q   <= instr_ok_d;
    end
  end

  // Cache write port, active only while the body streams through in LOAD.
  always_ff @(posedge clk) begin
    if (cen && cache_we) begin
      cache_q[idx_q] <= rom_data;
    end
  end

  assign instr      = instr_q;
  assign instr_ok   = instr_ok_q;
  assign loop_start = loop_start_q;
  assign pc_hold    = (state_q == ST_REPLAY);
  assign irq_mask   = (state_q == ST_LOAD) || (state_q == ST_REPLAY);

endmodule
